gf2_matmul_seq: RTL

Sequenced N x N matrix multiplier over GF(2). Elements are bits, multiply is AND and add is XOR. The block loads A and B serially as bit streams, computes C = A x B one element per cycle, then streams C out serially with backpressure. It is the controlled, handshaked replacement for the free-running serial matrix multiply datapath, and sits between a bit-serial producer and consumer.

---
 rtl/gf2_matmul_seq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/gf2_matmul_seq.sv
`default_nettype none
// ============================================================================
// Module      : gf2_matmul_seq
// Description : Sequenced N x N matrix multiplier over GF(2). A and B are
//               loaded as row-major bit streams, C = A x B is computed one
//               element per cycle, and C is streamed out with backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module gf2_matmul_seq #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic in_valid,
    input  logic a_in,
    input  logic b_in,
    output logic in_ready,
    output logic c_out,
    output logic c_valid,
    input  logic c_ready,
    output logic busy,
    output logic done
);

    localparam int NN = N * N;
    localparam int CW = $clog2(N * N + 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_LOAD    = 2'd1;
    localparam logic [1:0] c_COMPUTE = 2'd2;
    localparam logic [1:0] c_DRAIN   = 2'd3;

    localparam logic [CW-1:0] c_LAST = CW'(NN - 1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [NN-1:0] r_a;
    logic [NN-1:0] r_b;
    logic [NN-1:0] r_c;
    logic          r_done;

    logic w_load_xfer;
    logic w_drain_xfer;
    logic w_last;
    logic w_dot;
    logic w_cbit;

    assign w_load_xfer  = (r_state == c_LOAD) && in_valid;
    assign w_drain_xfer = (r_state == c_DRAIN) && c_ready;
    assign w_last       = (r_cnt == c_LAST);

    // Dot product of row i of A with column j of B for the element under the counter
    always_comb begin
        w_dot = 1'b0;
        for (int e = 0; e < NN; e++) begin
            if (r_cnt == CW'(e)) begin
                for (int k = 0; k < N; k++) begin
                    w_dot = w_dot ^ (r_a[(e / N) * N + k] & r_b[k * N + (e % N)]);
                end
            end
        end
    end

    // Select the C element under the counter for the output stream
    always_comb begin
        w_cbit = 1'b0;
        for (int e = 0; e < NN; e++) begin
            if (r_cnt == CW'(e)) begin
                w_cbit = r_c[e];
            end
        end
    end

    // Sequencer: state, shared element counter and the done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_cnt <= '0;
                    if (start) begin
                        r_state <= c_LOAD;
                    end
                end
                c_LOAD: begin
                    if (w_load_xfer) begin
                        if (w_last) begin
                            r_state <= c_COMPUTE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                c_COMPUTE: begin
                    if (w_last) begin
                        r_state <= c_DRAIN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_DRAIN: begin
                    if (w_drain_xfer) begin
                        if (w_last) begin
                            r_state <= c_IDLE;
                            r_cnt   <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Matrix storage: A/B written on load transfers, C written during compute.
    // Not cleared between operations since every element is rewritten before use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= '0;
            r_b <= '0;
            r_c <= '0;
        end else begin
            for (int e = 0; e < NN; e++) begin
                if (r_cnt == CW'(e)) begin
                    if (w_load_xfer) begin
                        r_a[e] <= a_in;
                        r_b[e] <= b_in;
                    end
                    if (r_state == c_COMPUTE) begin
                        r_c[e] <= w_dot;
                    end
                end
            end
        end
    end

    assign in_ready = (r_state == c_LOAD);
    assign c_valid  = (r_state == c_DRAIN);
    assign c_out    = (r_state == c_DRAIN) ? w_cbit : 1'b0;
    assign busy     = (r_state != c_IDLE);
    assign done     = r_done;

endmodule
`default_nettype wire
